// File: rtl/bangbang_loop_ctrl.sv
// bangbang_loop_ctrl
//   Bang-bang (early/late) phase-locking controller. A reference clock and the
//   generated oscillator clock are sampled in the fpga_clk_i domain; on every
//   rising reference edge the sampled generated clock gives a one-bit phase
//   decision. A proportional-integral filter turns the decisions into an
//   unsigned oscillator control word.
//
// Ports
//   fpga_clk_i  in   sole clock, all state on its rising edge
//   reset_i     in   asynchronous, active-high reset
//   ref_i       in   reference clock (asynchronous)
//   gen_i       in   generated clock (asynchronous)
//   mode_i      in   00 OFF, 01 TRACK, 10 HOLD, 11 MANUAL
//   manual_i    in   control word applied in MANUAL
//   ctrl_o      out  registered oscillator control word
//   pd_valid_o  out  one-cycle strobe per phase decision
//   pd_early_o  out  last decision (1 = gen leading, 0 = gen lagging)
//   lock_o      out  lock indicator
//   sat_o       out  integrator sitting at either signed limit
//
// Handshake: pd_valid_o is a plain strobe with no ready. It is high for exactly
// one cycle per decision; pd_early_o, lock_o and the integrator change on the
// same edge that raises it, and ctrl_o follows one cycle later.
module bangbang_loop_ctrl #(
    parameter int CTRL_WIDTH = 4,
    parameter int INT_WIDTH  = 12,
    parameter int KI_SHIFT   = 4,
    parameter int KP         = 1,
    parameter int LOCK_COUNT = 16
) (
    input  logic                  fpga_clk_i,
    input  logic                  reset_i,
    input  logic                  ref_i,
    input  logic                  gen_i,
    input  logic [1:0]            mode_i,
    input  logic [CTRL_WIDTH-1:0] manual_i,
    output logic [CTRL_WIDTH-1:0] ctrl_o,
    output logic                  pd_valid_o,
    output logic                  pd_early_o,
    output logic                  lock_o,
    output logic                  sat_o
);

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_TRACK  = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;
    localparam logic [1:0] MODE_MANUAL = 2'b11;

    localparam int MID      = 2 ** (CTRL_WIDTH - 1);
    localparam int CTRL_MAX = 2 ** CTRL_WIDTH - 1;
    localparam int CNT_W    = $clog2(LOCK_COUNT + 1);

    localparam logic [CTRL_WIDTH-1:0]        MID_CTRL = {1'b1, {(CTRL_WIDTH-1){1'b0}}};
    localparam logic signed [INT_WIDTH-1:0]  ACC_MAX  = {1'b0, {(INT_WIDTH-1){1'b1}}};
    localparam logic signed [INT_WIDTH-1:0]  ACC_MIN  = {1'b1, {(INT_WIDTH-1){1'b0}}};
    localparam logic signed [INT_WIDTH-1:0]  ACC_ONE  = 1;
    localparam logic [CNT_W-1:0]             CNT_ONE  = 1;
    localparam logic [CNT_W-1:0]             LOCK_TGT = CNT_W'(LOCK_COUNT);

    // Synchronisers and edge detector
    logic       ref_s1, ref_s2, ref_d;
    logic       gen_s1, gen_s2;
    logic [1:0] fill;
    logic       ref_edge;

    // Loop filter state
    logic signed [INT_WIDTH-1:0] int_acc;
    logic signed [INT_WIDTH-1:0] int_step;
    logic signed [INT_WIDTH-1:0] int_term;
    logic signed [INT_WIDTH-1:0] int_preload;
    logic signed [31:0]          hold_sum;
    logic signed [31:0]          track_sum;
    logic [CTRL_WIDTH-1:0]       ctrl_hold;
    logic [CTRL_WIDTH-1:0]       ctrl_track;

    // Lock detector state
    logic             have_prev;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_next;

    function automatic logic [CTRL_WIDTH-1:0] clamp_ctrl(input logic signed [31:0] v);
        if (v < 0) begin
            return '0;
        end else if (v > CTRL_MAX) begin
            return '1;
        end else begin
            return v[CTRL_WIDTH-1:0];
        end
    endfunction

    always_comb begin
        // The synchroniser flops all clear on reset, so a reference that is
        // already high at release would look like a rising edge. Edges are
        // only trusted once the pipeline holds three real samples.
        ref_edge = ref_s2 & ~ref_d & (fill == 2'd3);

        // Saturating +/-1 step: gen sampled high means gen leads, step down.
        int_step = int_acc;
        if (gen_s2) begin
            if (int_acc != ACC_MIN) int_step = int_acc - ACC_ONE;
        end else begin
            if (int_acc != ACC_MAX) int_step = int_acc + ACC_ONE;
        end

        // Proportional term uses the decision already latched in pd_early_o,
        // because ctrl_o is updated the cycle after the decision.
        int_term  = int_acc >>> KI_SHIFT;
        hold_sum  = MID + 32'(int_term);
        track_sum = hold_sum + (pd_early_o ? -KP : KP);
        ctrl_hold  = clamp_ctrl(hold_sum);
        ctrl_track = clamp_ctrl(track_sum);

        // Preload so that the integral term alone reproduces manual_i.
        int_preload = INT_WIDTH'(($signed({1'b0, manual_i}) - MID) <<< KI_SHIFT);

        // Alternation counter; the first decision after (re)entering TRACK
        // has nothing to compare with and only seeds the history.
        lock_cnt_next = '0;
        if (have_prev && (gen_s2 != pd_early_o)) begin
            lock_cnt_next = (lock_cnt == LOCK_TGT) ? lock_cnt : lock_cnt + CNT_ONE;
        end
    end

    assign sat_o = (int_acc == ACC_MAX) || (int_acc == ACC_MIN);

    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            ref_s1     <= 1'b0;
            ref_s2     <= 1'b0;
            ref_d      <= 1'b0;
            gen_s1     <= 1'b0;
            gen_s2     <= 1'b0;
            fill       <= 2'd0;
            int_acc    <= '0;
            ctrl_o     <= MID_CTRL;
            pd_valid_o <= 1'b0;
            pd_early_o <= 1'b0;
            lock_o     <= 1'b0;
            lock_cnt   <= '0;
            have_prev  <= 1'b0;
        end else begin
            // Synchronisers run in every mode.
            ref_s1 <= ref_i;
            ref_s2 <= ref_s1;
            ref_d  <= ref_s2;
            gen_s1 <= gen_i;
            gen_s2 <= gen_s1;
            if (fill != 2'd3) fill <= fill + 2'd1;

            pd_valid_o <= 1'b0;

            case (mode_i)
                MODE_TRACK: begin
                    if (ref_edge) begin
                        pd_valid_o <= 1'b1;
                        pd_early_o <= gen_s2;
                        int_acc    <= int_step;
                        lock_cnt   <= lock_cnt_next;
                        lock_o     <= (lock_cnt_next == LOCK_TGT);
                        have_prev  <= 1'b1;
                    end
                    if (pd_valid_o) ctrl_o <= ctrl_track;
                end
                MODE_HOLD: begin
                    ctrl_o    <= ctrl_hold;
                    lock_o    <= 1'b0;
                    lock_cnt  <= '0;
                    have_prev <= 1'b0;
                end
                MODE_MANUAL: begin
                    ctrl_o    <= manual_i;
                    int_acc   <= int_preload;
                    lock_o    <= 1'b0;
                    lock_cnt  <= '0;
                    have_prev <= 1'b0;
                end
                default: begin // MODE_OFF
                    ctrl_o    <= MID_CTRL;
                    int_acc   <= '0;
                    lock_o    <= 1'b0;
                    lock_cnt  <= '0;
                    have_prev <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bangbang_loop_ctrl.sv
// Self-checking bench for bangbang_loop_ctrl with default parameters.
// ref_i/gen_i are driven on falling fpga_clk_i edges; outputs are sampled on
// falling edges. A transaction-level model tracks the integrator value, the
// decision history and the expected control word.
module tb_bangbang_loop_ctrl;

    localparam int CW   = 4;
    localparam int MID  = 8;
    localparam int CMAX = 15;
    localparam int IMAX = 2047;
    localparam int IMIN = -2048;
    localparam int KIDIV = 16;
    localparam int KP   = 1;
    localparam int LC   = 16;

    localparam logic [1:0] M_OFF = 2'b00, M_TRACK = 2'b01, M_HOLD = 2'b10, M_MANUAL = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic ref_in, gen_in;
    logic [1:0] mode;
    logic [CW-1:0] manual;
    logic [CW-1:0] ctrl;
    logic pd_valid, pd_early, lock, sat;

    always #5 clk = ~clk;

    bangbang_loop_ctrl dut (
        .fpga_clk_i (clk),
        .reset_i    (rst),
        .ref_i      (ref_in),
        .gen_i      (gen_in),
        .mode_i     (mode),
        .manual_i   (manual),
        .ctrl_o     (ctrl),
        .pd_valid_o (pd_valid),
        .pd_early_o (pd_early),
        .lock_o     (lock),
        .sat_o      (sat)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [CW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_int  = 0;
    int m_ctrl = MID;
    bit m_early = 1'b0;
    bit dec_q[$];

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q--;
        return q;
    endfunction

    function automatic int clampc(input int v);
        if (v < 0) return 0;
        if (v > CMAX) return CMAX;
        return v;
    endfunction

    // Number of consecutive alternations at the tail of the decision history.
    function automatic int alt_run();
        int run;
        run = 0;
        for (int j = dec_q.size() - 1; j >= 1; j--) begin
            if (dec_q[j] != dec_q[j-1]) run++;
            else break;
        end
        return run;
    endfunction

    function automatic bit m_lock();
        return alt_run() >= LC;
    endfunction

    function automatic bit m_sat();
        return (m_int == IMAX) || (m_int == IMIN);
    endfunction

    task automatic model_decision(input bit g);
        int dir;
        dir = g ? -1 : 1;
        m_int = m_int + dir;
        if (m_int > IMAX) m_int = IMAX;
        if (m_int < IMIN) m_int = IMIN;
        dec_q.push_back(g);
        m_early = g;
        m_ctrl = clampc(MID + floor_div(m_int, KIDIV) + KP * dir);
        exp_q.push_back(m_ctrl[CW-1:0]);
    endtask

    // ---------------- driver tasks ----------------
    // One reference rising edge with gen at level g. Entered at a falling edge.
    task automatic do_edge(input bit g, input bit in_track);
        int lo;
        int seen;
        int prev_ctrl;
        logic [CW-1:0] exp_ctrl;
        lo = $urandom_range(2, 3);
        ref_in = 1'b0;
        gen_in = g;
        repeat (lo) @(negedge clk);
        prev_ctrl = m_ctrl;
        if (in_track) model_decision(g);
        ref_in = 1'b1;
        seen = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (pd_valid) seen++;
            if (in_track && i == 3) begin
                check_eq("pd_valid_lat", pd_valid, 1);
                check_eq("pd_early", pd_early, g);
                check_eq("int_acc", dut.int_acc, m_int);
                check_eq("sat", sat, m_sat());
                check_eq("lock", lock, m_lock());
                check_eq("ctrl_before", ctrl, prev_ctrl);
            end
            if (in_track && i == 4) begin
                exp_ctrl = exp_q.pop_front();
                check_eq("ctrl_after", ctrl, exp_ctrl);
            end
        end
        check_eq("pd_count", seen, in_track ? 1 : 0);
        check_eq("ctrl_end", ctrl, m_ctrl);
    endtask

    task automatic set_mode(input logic [1:0] m, input logic [CW-1:0] man);
        mode = m;
        manual = man;
        @(negedge clk);
        @(negedge clk);
        case (m)
            M_OFF:    begin m_int = 0; m_ctrl = MID; dec_q.delete(); end
            M_HOLD:   begin m_ctrl = clampc(MID + floor_div(m_int, KIDIV)); dec_q.delete(); end
            M_MANUAL: begin m_ctrl = int'(man); m_int = (int'(man) - MID) * KIDIV; dec_q.delete(); end
            default:  ;
        endcase
        check_eq("mode_ctrl", ctrl, m_ctrl);
        check_eq("mode_int", dut.int_acc, m_int);
        check_eq("mode_lock", lock, m_lock());
        check_eq("mode_sat", sat, m_sat());
        check_eq("mode_pdv", pd_valid, 0);
    endtask

    // Edge whose detection cycle coincides with leaving TRACK: must be dropped.
    task automatic drop_edge();
        int seen;
        ref_in = 1'b0;
        gen_in = $urandom_range(0, 1);
        repeat (3) @(negedge clk);
        ref_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mode = M_HOLD;
        m_ctrl = clampc(MID + floor_div(m_int, KIDIV));
        dec_q.delete();
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (pd_valid) seen++;
        end
        check_eq("drop_pdv", seen, 0);
        check_eq("drop_int", dut.int_acc, m_int);
        check_eq("drop_ctrl", ctrl, m_ctrl);
        set_mode(M_TRACK, manual);
    endtask

    task automatic count_idle(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (pd_valid) seen++;
        end
        check_eq(tag, seen, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        ref_in = 1'b0;
        gen_in = 1'b0;
        mode = M_TRACK;
        manual = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ctrl", ctrl, MID);
        check_eq("rst_pdv", pd_valid, 0);
        check_eq("rst_early", pd_early, 0);
        check_eq("rst_lock", lock, 0);
        check_eq("rst_sat", sat, 0);
        rst = 1'b0;

        // Idle TRACK: nothing moves.
        count_idle("idle_pdv", 20);
        check_eq("idle_ctrl", ctrl, MID);
        check_eq("idle_lock", lock, 0);
        check_eq("idle_sat", sat, 0);

        // gen held low: lagging decisions push the word up.
        do_edge(1'b0, 1'b1);
        check_eq("lag1_int", dut.int_acc, 1);
        check_eq("lag1_ctrl", ctrl, 9);
        repeat (15) do_edge(1'b0, 1'b1);
        check_eq("lag16_int", dut.int_acc, 16);
        check_eq("lag16_ctrl", ctrl, 10);

        // Alternating decisions reach lock; one repeat drops it.
        for (int i = 0; i < 17; i++) begin
            do_edge(i[0] ? 1'b0 : 1'b1, 1'b1);
            if (i == 14) check_eq("lock_pre", lock, 0);
            if (i == 15) check_eq("lock_rise", lock, 1);
        end
        do_edge(1'b1, 1'b1);
        check_eq("lock_fall", lock, 0);

        // Random decisions.
        repeat (120) do_edge($urandom_range(0, 1), 1'b1);

        // Edge discarded while leaving TRACK.
        drop_edge();

        // Bumpless MANUAL -> TRACK.
        set_mode(M_MANUAL, 4'd12);
        check_eq("man_ctrl", ctrl, 12);
        check_eq("man_int", dut.int_acc, 64);
        set_mode(M_TRACK, 4'd12);
        do_edge(1'b0, 1'b1);
        check_eq("bump_int", dut.int_acc, 65);
        check_eq("bump_ctrl", ctrl, 13);

        // Random mixture of modes.
        repeat (60) begin
            case ($urandom_range(0, 7))
                0: begin set_mode(M_MANUAL, 4'($urandom_range(0, 15))); set_mode(M_TRACK, manual); end
                1: begin set_mode(M_HOLD, manual); do_edge($urandom_range(0, 1), 1'b0); set_mode(M_TRACK, manual); end
                2: begin set_mode(M_OFF, manual); do_edge($urandom_range(0, 1), 1'b0); set_mode(M_TRACK, manual); end
                default: do_edge($urandom_range(0, 1), 1'b1);
            endcase
        end

        // Low saturation.
        set_mode(M_OFF, manual);
        set_mode(M_TRACK, manual);
        repeat (2100) do_edge(1'b1, 1'b1);
        check_eq("satlo_int", dut.int_acc, IMIN);
        check_eq("satlo_sat", sat, 1);
        check_eq("satlo_ctrl", ctrl, 0);
        do_edge(1'b0, 1'b1);
        check_eq("satlo_leave", sat, 0);

        // High saturation and HOLD clamping.
        set_mode(M_OFF, manual);
        set_mode(M_TRACK, manual);
        repeat (2100) do_edge(1'b0, 1'b1);
        check_eq("sathi_int", dut.int_acc, IMAX);
        check_eq("sathi_sat", sat, 1);
        check_eq("sathi_ctrl", ctrl, CMAX);
        set_mode(M_HOLD, manual);
        do_edge(1'b1, 1'b0);
        check_eq("hold_int", dut.int_acc, IMAX);
        set_mode(M_TRACK, manual);

        // Asynchronous reset mid-operation with int_acc = 40.
        set_mode(M_MANUAL, 4'd11);
        set_mode(M_TRACK, 4'd11);
        repeat (8) do_edge(1'b1, 1'b1);
        check_eq("pre_rst_int", dut.int_acc, 40);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_ctrl", ctrl, MID);
        check_eq("arst_pdv", pd_valid, 0);
        check_eq("arst_early", pd_early, 0);
        check_eq("arst_lock", lock, 0);
        check_eq("arst_sat", sat, 0);
        check_eq("arst_int", dut.int_acc, 0);
        @(negedge clk);
        rst = 1'b0;
        m_int = 0; m_ctrl = MID; m_early = 1'b0; dec_q.delete(); exp_q.delete();
        // ref_in is still high: release must not create a decision.
        count_idle("post_rst_pdv", 8);
        do_edge(1'b0, 1'b1);
        check_eq("post_rst_int", dut.int_acc, 1);
        check_eq("post_rst_ctrl", ctrl, 9);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bangbang_loop_ctrl.md
BANGBANG_LOOP_CTRL -- requirements
Module: bangbang_loop_ctrl

Interface
REQ-001 Parameter CTRL_WIDTH, default 4: width of the oscillator control word ctrl_o.
REQ-002 Parameter INT_WIDTH, default 12: signed integrator width; SHALL be greater than CTRL_WIDTH+KI_SHIFT.
REQ-003 Parameter KI_SHIFT, default 4: integrator fractional bits; integral term = int_acc >>> KI_SHIFT (arithmetic).
REQ-004 Parameter KP, default 1: proportional step added per decision, unsigned integer.
REQ-005 Parameter LOCK_COUNT, default 16: consecutive alternating decisions required for lock.
REQ-006 fpga_clk_i  in  1  sole clock; all state on its rising edge.
REQ-007 reset_i  in  1  asynchronous, active-high reset.
REQ-008 ref_i  in  1  reference clock, asynchronous to fpga_clk_i.
REQ-009 gen_i  in  1  generated (oscillator) clock, asynchronous to fpga_clk_i.
REQ-010 mode_i  in  2  00 OFF, 01 TRACK, 10 HOLD, 11 MANUAL.
REQ-011 manual_i  in  CTRL_WIDTH  control word used in MANUAL.
REQ-012 ctrl_o  out  CTRL_WIDTH  registered oscillator control word.
REQ-013 pd_valid_o  out  1  one-cycle strobe per phase decision.
REQ-014 pd_early_o  out  1  last decision, 1 = gen early (leading), 0 = late.
REQ-015 lock_o  out  1  lock indicator.
REQ-016 sat_o  out  1  integrator at either signed limit.

Function
REQ-017 ref_i and gen_i SHALL each pass a two-flop synchroniser; ref edge = synchronised ref high AND one-cycle-delayed copy low.
REQ-018 On a ref edge in TRACK, the decision SHALL be early if synchronised gen is 1 (dir = -1), else late (dir = +1).
REQ-019 In the cycle after the ref edge: pd_valid_o = 1, pd_early_o updated, int_acc <= sat(int_acc + dir), all simultaneously.
REQ-020 int_acc SHALL saturate at -2^(INT_WIDTH-1) and 2^(INT_WIDTH-1)-1, never wrap; sat_o = 1 while at either limit.
REQ-021 Let MID = 2^(CTRL_WIDTH-1); in TRACK, ctrl_o SHALL update one cycle after pd_valid_o to clamp(MID + (int_acc >>> KI_SHIFT) + KP*dir, 0, 2^CTRL_WIDTH-1), computed at full signed precision before clamping.
REQ-022 Total latency synchronised ref rise to ctrl_o change: edge-detect cycle, +1 pd_valid_o, +1 ctrl_o.
REQ-023 OFF: int_acc <= 0, ctrl_o <= MID, lock cleared, no pd_valid_o.
REQ-024 HOLD: int_acc frozen, ref edges ignored (no pd_valid_o), ctrl_o <= clamp(MID + (int_acc >>> KI_SHIFT)) with no KP term.
REQ-025 MANUAL: ctrl_o <= manual_i; int_acc <= (manual_i - MID) << KI_SHIFT each cycle so the switch to TRACK is bumpless; no pd_valid_o.
REQ-026 Mode changes take effect on the next clock edge; an edge detected in the cycle mode leaves TRACK SHALL be discarded.
REQ-027 Lock counter SHALL increment when a decision differs from the previous one, reset to 0 on two equal consecutive decisions; lock_o = 1 once count reaches LOCK_COUNT (counter saturates there).
REQ-028 lock_o SHALL deassert in the cycle after the first repeated decision, and whenever mode is not TRACK.
REQ-029 Synchroniser state SHALL run in all modes so no spurious edge is produced on entry to TRACK.

Reset
REQ-030 On reset_i assertion, immediately and independent of fpga_clk_i: ctrl_o = MID, int_acc = 0, pd_valid_o = 0, pd_early_o = 0, lock_o = 0, sat_o = 0, lock counter = 0, synchroniser and edge flops = 0.
REQ-031 Reset asserted mid-operation SHALL abandon any pending decision; first decision after release requires a fresh ref edge.

Verification (defaults: CTRL_WIDTH=4, MID=8, INT_WIDTH=12, KI_SHIFT=4, KP=1, LOCK_COUNT=16)
REQ-032 Reset released, mode TRACK, no ref edges -> ctrl_o = 8, lock_o = 0, sat_o = 0, no pd_valid_o.
REQ-033 TRACK, gen_i held 0, 1 ref edge -> pd_early_o = 0, int_acc = 1, ctrl_o = 9; after 16 edges -> int_acc = 16, ctrl_o = 10.
REQ-034 TRACK, gen_i held 1, 2100 ref edges -> int_acc = -2048, sat_o = 1, ctrl_o = 0 (clamped), no wrap.
REQ-035 gen_i level alternating per ref edge -> lock_o rises after 16th alternation; one repeated decision -> lock_o = 0 next cycle.
REQ-036 MANUAL, manual_i = 12 -> ctrl_o = 12, int_acc = 64; switch to TRACK, gen_i = 0, one edge -> int_acc = 65, ctrl_o = 13.
REQ-037 reset_i pulsed between clock edges during TRACK with int_acc = 40 -> all outputs at reset values before next clock edge.
